// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode pipeline front end.
// Holds the default widths, the special opcodes, the fixed instruction field
// layout and the fetch state encoding used by the fetch stage.
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Fixed field layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction field splitter, shared by fetch and decode stages.
// Ports: instr in; opcode/rd/rs1/rs2 field slices out; is_nop/is_halt flags out.
// Latency: zero (pure slices and compares), no flow control.
module instr_field_decode
    import cpu_pkg::*;
#(
    parameter int IW = cpu_pkg::INSTR_W
) (
    input  logic [IW-1:0] instr,
    output logic [3:0]    opcode,
    output logic [3:0]    rd,
    output logic [3:0]    rs1,
    output logic [3:0]    rs2,
    output logic          is_nop,
    output logic          is_halt
);

    assign opcode  = instr[OPC_MSB:OPC_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign rs1     = instr[RS1_MSB:RS1_LSB];
    assign rs2     = instr[RS2_MSB:RS2_LSB];
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, latches one instruction per fetch and offers it
// to execute over valid/ready; detects HALT/NOP and takes PC redirects.
// Ports: clk/rst, start, imem_addr/imem_instr (combinational memory),
// instr_valid/instr_ready + decoded fields + pc_out, redirect_valid/target,
// halted (sticky), instr_count (saturating handshake count).
// Latency: start -> FETCH next cycle -> instr_valid the cycle after; an
// instruction is held indefinitely while instr_ready is low.
module instr_fetch_unit #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int INSTR_W  = cpu_pkg::INSTR_W,
    parameter int SKIP_NOP = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;

    // Flags on the word currently presented by memory, used in FETCH.
    logic [3:0] mem_opcode, mem_rd, mem_rs1, mem_rs2;
    logic       mem_is_nop, mem_is_halt;

    // Flags of the held word are not needed here; the decode stage uses them.
    logic       ir_is_nop, ir_is_halt;
    logic       unused_decode;

    instr_field_decode #(.IW(INSTR_W)) u_mem_decode (
        .instr   (imem_instr),
        .opcode  (mem_opcode),
        .rd      (mem_rd),
        .rs1     (mem_rs1),
        .rs2     (mem_rs2),
        .is_nop  (mem_is_nop),
        .is_halt (mem_is_halt)
    );

    instr_field_decode #(.IW(INSTR_W)) u_ir_decode (
        .instr   (ir),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .is_nop  (ir_is_nop),
        .is_halt (ir_is_halt)
    );

    assign unused_decode = ^{mem_opcode, mem_rd, mem_rs1, mem_rs2, ir_is_nop, ir_is_halt};

    // PC is only ever nonzero outside IDLE, so the address is simply the PC.
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    if (redirect_valid) begin
                        // The word on the bus belongs to the squashed path:
                        // do not latch it and do not react to a HALT in it.
                        pc    <= redirect_target;
                        state <= FETCH;
                    end else begin
                        ir     <= imem_instr;
                        pc_out <= pc;
                        pc     <= pc + PC_ONE;
                        if (mem_is_halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else if ((SKIP_NOP != 0) && mem_is_nop) begin
                            state <= FETCH;
                        end else begin
                            state       <= ISSUE;
                            instr_valid <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    // A handshake completing alongside a redirect still counts.
                    if (instr_ready && (instr_count != CNT_MAX)) begin
                        instr_count <= instr_count + CNT_ONE;
                    end
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    if (instr_ready || redirect_valid) begin
                        state       <= FETCH;
                        instr_valid <= 1'b0;
                    end
                end

                HALTED: begin
                    state <= HALTED;
                end

                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic instr_ready;
    logic redirect_valid;
    logic [7:0] redirect_target;

    always #5 clk = ~clk;

    // DUT A: SKIP_NOP=0
    logic [7:0]  addr_a, pc_out_a;
    logic [15:0] instr_a, count_a;
    logic        valid_a, halted_a;
    logic [3:0]  op_a, rd_a, rs1_a, rs2_a;
    logic [15:0] mem_a [0:255];
    assign instr_a = mem_a[addr_a];

    // DUT B: SKIP_NOP=1
    logic [7:0]  addr_b, pc_out_b;
    logic [15:0] instr_b, count_b;
    logic        valid_b, halted_b;
    logic [3:0]  op_b, rd_b, rs1_b, rs2_b;
    logic [15:0] mem_b [0:255];
    assign instr_b = mem_b[addr_b];

    // DUT C: 2-bit counter for saturation
    logic [7:0]  addr_c, pc_out_c;
    logic [15:0] instr_c;
    logic [1:0]  count_c;
    logic        valid_c, halted_c;
    logic [3:0]  op_c, rd_c, rs1_c, rs2_c;
    logic [15:0] mem_c [0:255];
    assign instr_c = mem_c[addr_c];

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .SKIP_NOP(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .imem_addr(addr_a), .imem_instr(instr_a),
        .instr_valid(valid_a), .instr_ready(instr_ready), .opcode(op_a), .rd(rd_a),
        .rs1(rs1_a), .rs2(rs2_a), .pc_out(pc_out_a), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halted(halted_a), .instr_count(count_a)
    );

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .SKIP_NOP(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .imem_addr(addr_b), .imem_instr(instr_b),
        .instr_valid(valid_b), .instr_ready(instr_ready), .opcode(op_b), .rd(rd_b),
        .rs1(rs1_b), .rs2(rs2_b), .pc_out(pc_out_b), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halted(halted_b), .instr_count(count_b)
    );

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .SKIP_NOP(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .start(start), .imem_addr(addr_c), .imem_instr(instr_c),
        .instr_valid(valid_c), .instr_ready(instr_ready), .opcode(op_c), .rd(rd_c),
        .rs1(rs1_c), .rs2(rs2_c), .pc_out(pc_out_c), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halted(halted_c), .instr_count(count_c)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start;
        logic        ready;
        logic        rv;
        logic [7:0]  tgt;
        logic        exp_valid;
        logic [15:0] exp_fields;
        logic [7:0]  exp_pc_out;
        logic [7:0]  exp_addr;
        logic [15:0] exp_count;
        logic        exp_halted;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    // Start pulse and advance until dut_a holds the instruction from addr 0.
    task automatic start_to_issue();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        int vcnt;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
            mem_c[i] = 16'h1234;
        end
        mem_a[0] = 16'h8123; mem_a[3] = 16'hF000; mem_a[255] = 16'h8000;
        mem_b[0] = 16'h8123; mem_b[3] = 16'hF000;

        //              start ready rv   tgt    valid fields    pc_out addr  count   halted
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'd0, 8'd0, 16'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h8123, 8'd0, 8'd1, 16'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h8123, 8'd0, 8'd1, 16'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 8'd1, 8'd2, 16'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'd1, 8'd2, 16'd2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 8'd2, 8'd3, 16'd2, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'd2, 8'd3, 16'd3, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'hF000, 8'd3, 8'd4, 16'd3, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h09, 1'b0, 16'hF000, 8'd3, 8'd4, 16'd3, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'hF000, 8'd3, 8'd4, 16'd3, 1'b1};

        // Reset state
        do_reset();
        check("rst_valid", valid_a, 1'b0);
        check("rst_addr", addr_a, 8'd0);
        check("rst_fields", {op_a, rd_a, rs1_a, rs2_a}, 16'h0000);
        check("rst_pc_out", pc_out_a, 8'd0);
        check("rst_count", count_a, 16'd0);
        check("rst_halted", halted_a, 1'b0);

        // Program run, SKIP_NOP=0, one vector per cycle
        for (int i = 0; i < 10; i++) begin
            start = vecs[i].start;
            instr_ready = vecs[i].ready;
            redirect_valid = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            step();
            check($sformatf("v%0d_valid", i), valid_a, vecs[i].exp_valid);
            check($sformatf("v%0d_fields", i), {op_a, rd_a, rs1_a, rs2_a}, vecs[i].exp_fields);
            check($sformatf("v%0d_pc_out", i), pc_out_a, vecs[i].exp_pc_out);
            check($sformatf("v%0d_addr", i), addr_a, vecs[i].exp_addr);
            check($sformatf("v%0d_count", i), count_a, vecs[i].exp_count);
            check($sformatf("v%0d_halted", i), halted_a, vecs[i].exp_halted);
        end
        start = 1'b0;
        redirect_valid = 1'b0;

        // SKIP_NOP=1: only the first instruction is issued
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_b) vcnt++;
        end
        check("skip_valid_cycles", vcnt, 1);
        check("skip_count", count_b, 16'd1);
        check("skip_halted", halted_b, 1'b1);
        check("skip_addr", addr_b, 8'd4);
        check("skip_valid_end", valid_b, 1'b0);

        // Backpressure: hold addr 0 for 5 cycles
        do_reset();
        start_to_issue();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), valid_a, 1'b1);
            check($sformatf("bp%0d_fields", i), {op_a, rd_a, rs1_a, rs2_a}, 16'h8123);
            check($sformatf("bp%0d_pc_out", i), pc_out_a, 8'd0);
            check($sformatf("bp%0d_addr", i), addr_a, 8'd1);
            check($sformatf("bp%0d_count", i), count_a, 16'd0);
            step();
        end
        instr_ready = 1'b1;
        step();
        check("bp_release_count", count_a, 16'd1);
        check("bp_release_valid", valid_a, 1'b0);

        // Redirect in ISSUE, ready=0: squashed, no count
        do_reset();
        start_to_issue();
        redirect_valid = 1'b1;
        redirect_target = 8'd3;
        step();
        redirect_valid = 1'b0;
        check("rd0_valid", valid_a, 1'b0);
        check("rd0_addr", addr_a, 8'd3);
        check("rd0_count", count_a, 16'd0);
        step();
        check("rd0_halted", halted_a, 1'b1);
        check("rd0_count_end", count_a, 16'd0);
        check("rd0_addr_end", addr_a, 8'd4);

        // Redirect in ISSUE, ready=1: handshake counts
        do_reset();
        start_to_issue();
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 8'd3;
        step();
        redirect_valid = 1'b0;
        check("rd1_count", count_a, 16'd1);
        check("rd1_addr", addr_a, 8'd3);
        step();
        check("rd1_halted", halted_a, 1'b1);
        check("rd1_count_end", count_a, 16'd1);

        // PC wrap: redirect to 255, issue from 255, PC wraps to 0
        do_reset();
        start_to_issue();
        redirect_valid = 1'b1;
        redirect_target = 8'd255;
        step();
        redirect_valid = 1'b0;
        check("wrap_fetch_addr", addr_a, 8'd255);
        step();
        check("wrap_valid", valid_a, 1'b1);
        check("wrap_pc_out", pc_out_a, 8'd255);
        check("wrap_opcode", op_a, 4'h8);
        check("wrap_addr", addr_a, 8'd0);

        // Reset mid-ISSUE
        do_reset();
        start_to_issue();
        check("mr_pre_valid", valid_a, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_valid", valid_a, 1'b0);
        check("mr_addr", addr_a, 8'd0);
        check("mr_fields", {op_a, rd_a, rs1_a, rs2_a}, 16'h0000);
        check("mr_pc_out", pc_out_a, 8'd0);
        check("mr_count", count_a, 16'd0);
        check("mr_halted", halted_a, 1'b0);
        step();
        step();
        check("mr_idle_valid", valid_a, 1'b0);
        check("mr_idle_addr", addr_a, 8'd0);
        start_to_issue();
        check("mr_resume_valid", valid_a, 1'b1);
        check("mr_resume_pc_out", pc_out_a, 8'd0);
        check("mr_resume_opcode", op_a, 4'h8);

        // Saturating counter on a 2-bit instance
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("sat_mid_count", count_c, 2'd2);
        for (int i = 0; i < 20; i++) step();
        check("sat_count", count_c, 2'd3);
        check("sat_halted", halted_c, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Sequential fetch stage that drives the instruction memory and consumes its output. It holds the program counter, latches each 16-bit instruction, and splits it into opcode/rd/rs1/rs2 fields. Decoded instructions go to the execute stage over a valid/ready handshake. It detects HALT and NOP and accepts PC redirects from execute. It sits between the combinational instruction memory and the execute/ALU stage.

Parameters:
ADDR_W, 8, instruction memory address width (PC width)
INSTR_W, 16, instruction width; fixed field layout [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
SKIP_NOP, 0, 1 = NOP (opcode 4'h0) is fetched but never issued
CNT_W, 16, width of issued-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin fetching from PC=0; honoured only in IDLE
imem_addr  out  ADDR_W  address to instruction memory, equals registered PC
imem_instr  in  INSTR_W  instruction from memory, combinational, valid same cycle as imem_addr
instr_valid  out  1  decoded instruction available
instr_ready  in  1  execute stage accepts instruction
opcode  out  4  IR[15:12]
rd  out  4  IR[11:8]
rs1  out  4  IR[7:4]
rs2  out  4  IR[3:0]
pc_out  out  ADDR_W  address the held instruction was fetched from
redirect_valid  in  1  load PC from redirect_target and squash held instruction
redirect_target  in  ADDR_W  new PC
halted  out  1  HALT fetched; sticky until rst
instr_count  out  CNT_W  count of completed handshakes, saturating

Behaviour:
- One clock (clk); synchronous active-high reset (rst). Reset sets state=IDLE, PC=0, IR=0, pc_out=0, instr_valid=0, halted=0, instr_count=0. All outputs are 0 after reset. Reset wins over every other input in the same cycle, including mid-ISSUE; the held instruction is discarded.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: imem_addr=0. When start=1, go to FETCH.
- FETCH: at the edge, IR<=imem_instr, pc_out<=PC, PC<=PC+1 (modulo 2^ADDR_W, 255 wraps to 0).
  - Next state is HALTED if imem_instr[15:12]==4'hF (halted<=1; HALT is never issued).
  - Otherwise, if SKIP_NOP=1 and the opcode is 4'h0, stay in FETCH.
  - Otherwise go to ISSUE.
- ISSUE: instr_valid=1. opcode/rd/rs1/rs2/pc_out stay stable until the handshake completes.
  - instr_ready=1 completes the handshake: instr_count increments (saturates at all-ones), next state FETCH.
  - instr_ready=0: hold the instruction indefinitely.
- Redirect:
  - In FETCH or ISSUE, redirect_valid=1 sets PC<=redirect_target, next state FETCH, and discards the latched/held IR. In FETCH it discards the IR just latched, so no HALT detection applies.
  - If redirect_valid and instr_ready are both 1 in ISSUE, the handshake counts as completed (instr_count increments) and the redirect also applies.
  - Ignored in IDLE and HALTED.
- HALTED: instr_valid=0, PC frozen. start and redirect_valid are ignored; only rst exits this state.
- Latency: start sampled at edge N, FETCH during cycle N+1, instr_valid=1 in cycle N+2. Peak throughput is one instruction per 2 cycles.
- The decode fields are pure slices of IR. They show the last latched IR even while instr_valid=0.

Decomposition:
- Shared package cpu_pkg: ADDR_W, INSTR_W, OP_NOP=4'h0, OP_HALT=4'hF, field bit positions, fetch state enum (IDLE/FETCH/ISSUE/HALTED).
- One natural sub-module: instr_field_decode (combinational IR -> opcode/rd/rs1/rs2, is_nop, is_halt). It is reused by the later decode stage.

Test Plan:
- Program {0:16'h8123, 1:0, 2:0, 3:16'hF000}, SKIP_NOP=0, ready=1, start pulse:
  - issues opcode=8, rd=1, rs1=2, rs2=3, pc_out=0, then two NOPs with pc_out=1 and 2;
  - after that halted=1, instr_valid=0, instr_count=3, imem_addr=4 frozen.
- Same program with SKIP_NOP=1: only the 16'h8123 handshake occurs, then halted=1, instr_count=1.
- Backpressure: ready=0 for 5 cycles in ISSUE of addr 0 -> instr_valid stays 1, fields/pc_out stay 8/1/2/3/0, imem_addr=1, instr_count=0. Raising ready gives instr_count=1 next cycle.
- Redirect in ISSUE with target=3 and ready=0 -> instr_valid=0 next cycle, FETCH at 3, halted=1, instr_count=0. Repeat with ready=1 -> instr_count=1, then halted=1.
- Wrap: stub memory returns 16'h8000 at 255. Redirect to 255 -> issue with pc_out=255, then imem_addr=0.
- Reset mid-ISSUE (rst=1 for 1 cycle while instr_valid=1) -> next cycle all outputs 0, state IDLE. A further start is required to resume, and the first issue is from pc_out=0.
